// File: rtl/booth_seq_multiplier_if.sv
// Operand/result bus between the result-select logic and the Booth multiplier.
interface booth_seq_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic               op_start;
  logic               op_clear;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  result, busy, done
  );

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output result, busy, done
  );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH steps per product.
// The product register only updates on completion, clear or reset, so downstream muxing can read it any time.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  booth_seq_multiplier_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    // Accumulator is one bit wider so -2^(WIDTH-1) can be subtracted without overflow
    m_ext = {m_q[WIDTH-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    sh = {sum[WIDTH], sum, q_q};

    if (bus.op_clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.op_start) begin
            m_d     = bus.multiplicand;
            q_d     = bus.multiplier;
            acc_d   = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            state_d = EXEC;
          end
        end
        EXEC: begin
          acc_d = sh[2*WIDTH+1:WIDTH+1];
          q_d   = sh[WIDTH:1];
          qm1_d = sh[0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = sh[2*WIDTH:1];
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == EXEC);
    done_d = (state_d == DONE);
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: table of products plus hand-written abort, clear and reset sequences.
module tb_booth_seq_multiplier;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.WIDTH(W)) bus ();

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int             chk_cnt  = 0;
  int             pass_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  vec_t           vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // inj >= 0: pulse op_start with 2 x 2 at that EXEC cycle (must be ignored)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int inj);
    int             cyc;
    int             n;
    bit             held;
    logic [2*W-1:0] r0;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.op_start     = 1'b1;
    exp_q.push_back(exp);
    r0   = bus.result;
    held = 1'b1;
    cyc  = 0;
    n    = 0;
    step();
    bus.op_start = 1'b0;
    while (!bus.done && n < 4 * W) begin
      if (bus.busy) cyc++;
      if (bus.result !== r0) held = 1'b0;
      if (cyc == inj) begin
        bus.op_start     = 1'b1;
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd2;
      end else begin
        bus.op_start = 1'b0;
      end
      n++;
      step();
    end
    bus.op_start = 1'b0;
    check("busy_cycles", 64'(cyc), 64'(W));
    check("done_busy", 64'({bus.done, bus.busy}), 64'b10);
    check("result_held_during_exec", 64'(held), 64'd1);
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL scoreboard_empty: got done with no expected product");
    end else begin
      check("product", bus.result, exp_q.pop_front());
    end
    r0 = bus.result;
    step();
    check("done_hold", 64'({bus.done, bus.busy}), 64'b10);
    check("result_hold", bus.result, r0);
  endtask

  initial begin
    vecs[0] = '{a: 32'd3,          b: 32'd4,          p: 64'h0000_0000_0000_000C};
    vecs[1] = '{a: 32'hFFFF_FFF9,  b: 32'd5,          p: 64'hFFFF_FFFF_FFFF_FFDD};
    vecs[2] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  p: 64'h4000_0000_0000_0000};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'h7FFF_FFFF,  p: 64'hC000_0000_8000_0000};
    vecs[4] = '{a: 32'h7FFF_FFFF,  b: 32'h7FFF_FFFF,  p: 64'h3FFF_FFFF_0000_0001};
    vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'h0000_0000_0000_0001};
    vecs[6] = '{a: 32'd0,          b: 32'h1234_5678,  p: 64'h0000_0000_0000_0000};
    vecs[7] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  p: 64'h0000_0001_0000_0000};
    vecs[8] = '{a: 32'h7FFF_FFFF,  b: 32'h8000_0000,  p: 64'hC000_0000_8000_0000};
    vecs[9] = '{a: 32'd6,          b: 32'd7,          p: 64'h0000_0000_0000_002A};

    reset            = 1'b1;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    step();
    step();
    check("reset_result", bus.result, 64'd0);
    check("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, -1);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, model(ra, rb), -1);
    end

    // start 6 x 7, then a stray start at EXEC cycle 10 must be ignored
    run_op(32'd2, 32'd2, 64'd4, -1);
    run_op(32'd6, 32'd7, 64'd42, 10);

    // 9 x 9 aborted by op_clear at EXEC cycle 5: 42 stays visible until the clear edge
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    bus.op_start     = 1'b1;
    exp_q.push_back(64'd81);
    step();
    bus.op_start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check("clear_pre_result", bus.result, 64'd42);
      step();
    end
    check("clear_pre_busy", 64'(bus.busy), 64'd1);
    check("clear_pre_result", bus.result, 64'd42);
    bus.op_clear = 1'b1;
    step();
    bus.op_clear = 1'b0;
    void'(exp_q.pop_back());
    check("clear_result", bus.result, 64'd0);
    check("clear_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    step();
    check("clear_stays_idle", 64'({bus.busy, bus.done}), 64'd0);

    // clear and start together: start is dropped
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd3;
    bus.op_start     = 1'b1;
    bus.op_clear     = 1'b1;
    step();
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    check("clear_start_busy", 64'({bus.busy, bus.done}), 64'd0);
    step();
    check("clear_start_idle", 64'({bus.busy, bus.done}), 64'd0);

    // asynchronous reset in the middle of EXEC, no clock edge needed
    run_op(32'd5, 32'd5, 64'd25, -1);
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd3;
    bus.op_start     = 1'b1;
    exp_q.push_back(64'd6);
    step();
    bus.op_start = 1'b0;
    step();
    step();
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    check("pre_reset_result", bus.result, 64'd25);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_result", bus.result, 64'd0);
    check("async_reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    void'(exp_q.pop_back());
    step();
    step();
    reset = 1'b0;
    run_op(32'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
